// File: rtl/vram_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vram_fetch
//  Description : Slot-synchronised video line fetcher. It requests 16-bit
//                words from the SDRAM controller on free slots, buffers them
//                in a small word FIFO and hands them out one byte at a time,
//                low byte first.
//  Revision    : 1.0  initial release
// ============================================================================
module vram_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slot_start,
    input  logic             cpu_slot,
    input  logic             line_start,
    input  logic [22:0]      base_addr,
    input  logic [LEN_W-1:0] line_words,
    output logic [22:0]      vram_addr,
    input  logic [15:0]      vram_dout,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_FETCH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [21:0]       r_ptr;
    logic [LEN_W-1:0]  r_remaining;
    logic [15:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_byte_sel;
    logic              r_underflow;
    logic              w_capture;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_load;
    logic              w_unused_ok;

    // Byte address bit 0 has no meaning for a word-wide fetch.
    assign w_unused_ok = base_addr[0];

    assign w_fifo_full = (r_count == CW'(FIFO_DEPTH));
    assign w_load      = line_start && (line_words != '0);
    // A pop happens when the high byte of the head word is consumed; a new
    // line wins over any pop in the same cycle.
    assign w_pop       = rd_en && rd_valid && r_byte_sel && !line_start;

    assign vram_addr = {r_ptr, 1'b0};
    assign rd_valid  = (r_count != '0);
    assign rd_data   = r_byte_sel ? r_mem[r_rd_ptr][15:8] : r_mem[r_rd_ptr][7:0];
    assign busy      = (r_state != S_IDLE);
    assign underflow = r_underflow;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a line start overrides whatever the slot logic wants.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        if (line_start) begin
            w_next = w_load ? S_ARM : S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: w_next = S_IDLE;
                S_ARM: begin
                    if (slot_start && !cpu_slot && !w_fifo_full) begin
                        w_next = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (slot_start) begin
                        w_capture = 1'b1;
                        w_next    = (r_remaining == LEN_W'(1)) ? S_IDLE : S_ARM;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Word pointer and remaining-word counter; the pointer wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
        end else if (w_load) begin
            r_ptr       <= base_addr[22:1];
            r_remaining <= line_words;
        end else if (w_capture) begin
            r_ptr       <= r_ptr + 22'd1;
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    // FIFO storage; stale contents are harmless because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_wr_ptr] <= vram_dout;
        end
    end

    // FIFO pointers and occupancy; any line start flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset || line_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte select and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (reset || line_start) begin
            r_byte_sel  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (rd_en) begin
            if (rd_valid) begin
                r_byte_sel <= ~r_byte_sel;
            end else begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vram_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_fetch
//  Description : Self-checking bench for vram_fetch. The SDRAM is modelled as
//                a fixed address->data function; expected byte streams are
//                built from the line base address and word count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vram_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        slot_start;
    logic        cpu_slot;
    logic        line_start;
    logic [22:0] base_addr;
    logic [7:0]  line_words;
    logic [22:0] vram_addr;
    logic [15:0] vram_dout;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        underflow;

    int          checks   = 0;
    int          failures = 0;
    int          phase    = 1;
    logic        edge_slot;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    vram_fetch #(.FIFO_DEPTH(4), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .slot_start (slot_start),
        .cpu_slot   (cpu_slot),
        .line_start (line_start),
        .base_addr  (base_addr),
        .line_words (line_words),
        .vram_addr  (vram_addr),
        .vram_dout  (vram_dout),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .underflow  (underflow)
    );

    // SDRAM contents: two fixed words for the directed line, a hash elsewhere.
    function automatic logic [15:0] word_at(input logic [22:0] a);
        if (a == 23'h001000) return 16'hBBAA;
        if (a == 23'h001002) return 16'hDDCC;
        return 16'(a[16:1] * 16'h9E37) ^ 16'h5AC3;
    endfunction

    assign vram_dout = word_at(vram_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs set before the call are consumed at the edge.
    task automatic step();
        @(posedge clk);
        edge_slot = slot_start;
        #1;
        phase      = (phase + 1) % 8;
        slot_start = (phase == 0);
        #1;
    endtask

    task automatic next_slot();
        do step(); while (!edge_slot);
    endtask

    // Expected byte stream of a line: consecutive words, low byte first.
    task automatic add_line(input logic [22:0] base, input int n);
        logic [21:0] p;
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            p = base[22:1] + 22'(i);
            w = word_at({p, 1'b0});
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
        end
    endtask

    task automatic pulse_line(input logic [22:0] base, input int n);
        base_addr  = base;
        line_words = 8'(n);
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        exp_q.delete();
        add_line(base, n);
    endtask

    // Consume the expected stream, optionally with random slots and pops.
    task automatic drain(input string tag, input bit rnd, input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            if (rnd) cpu_slot = ($urandom_range(0, 2) == 0);
            if (rd_valid && (!rnd || $urandom_range(0, 1) == 1)) begin
                chk($sformatf("%s byte%0d", tag, exp_q.size()), rd_data, exp_q[0]);
                void'(exp_q.pop_front());
                rd_en = 1'b1;
                step();
                rd_en = 1'b0;
            end else begin
                step();
            end
            n++;
        end
        cpu_slot = 1'b0;
        chk({tag, " left"}, exp_q.size(), 0);
        chk({tag, " end busy"}, busy, 0);
        chk({tag, " end valid"}, rd_valid, 0);
        chk({tag, " underflow"}, underflow, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        slot_start = 1'b0;
        cpu_slot   = 1'b0;
        line_start = 1'b0;
        base_addr  = '0;
        line_words = '0;
        rd_en      = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst vram_addr", vram_addr, 0);
        chk("rst rd_valid", rd_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst underflow", underflow, 0);

        // Basic two-word line.
        pulse_line(23'h001000, 2);
        chk("t1 busy", busy, 1);
        chk("t1 addr0", vram_addr, 23'h001000);
        next_slot();
        chk("t1 addr0 held", vram_addr, 23'h001000);
        chk("t1 no data yet", rd_valid, 0);
        next_slot();
        chk("t1 valid", rd_valid, 1);
        chk("t1 first byte", rd_data, 8'hAA);
        chk("t1 addr1", vram_addr, 23'h001002);
        next_slot();
        chk("t1 busy mid", busy, 1);
        next_slot();
        chk("t1 busy falls", busy, 0);
        chk("t1 addr end", vram_addr, 23'h001004);
        drain("t1", 0, 100);

        // CPU owns the first two ARM slots.
        cpu_slot = 1'b1;
        pulse_line(23'h001000, 2);
        next_slot();
        chk("t2 addr held a", vram_addr, 23'h001000);
        next_slot();
        chk("t2 addr held b", vram_addr, 23'h001000);
        cpu_slot = 1'b0;
        next_slot();
        chk("t2 not yet", rd_valid, 0);
        next_slot();
        chk("t2 captured", rd_valid, 1);
        chk("t2 first byte", rd_data, 8'hAA);
        drain("t2", 0, 200);

        // FIFO fills and the fetch stalls until bytes are consumed.
        pulse_line(23'h003000, 6);
        repeat (12) next_slot();
        chk("t3 stalled busy", busy, 1);
        chk("t3 stalled addr", vram_addr, 23'h003008);
        chk("t3 head", rd_data, exp_q[0]);
        drain("t3", 0, 400);

        // Odd base address and pointer wrap.
        pulse_line(23'h7FFFFF, 2);
        chk("t4 addr top", vram_addr, 23'h7FFFFE);
        next_slot();
        next_slot();
        chk("t4 addr wrap", vram_addr, 23'h000000);
        drain("t4", 0, 200);

        // Zero-length line flushes buffered data.
        pulse_line(23'h001000, 4);
        next_slot();
        next_slot();
        chk("t5 has data", rd_valid, 1);
        pulse_line(23'h005000, 0);
        chk("t5 flushed", rd_valid, 0);
        chk("t5 idle", busy, 0);
        repeat (4) next_slot();
        chk("t5 stays empty", rd_valid, 0);

        // Restart during FETCH on a non-slot edge.
        pulse_line(23'h001000, 4);
        next_slot();
        pulse_line(23'h002000, 2);
        chk("t6 flushed", rd_valid, 0);
        chk("t6 new addr", vram_addr, 23'h002000);
        chk("t6 busy", busy, 1);
        next_slot();
        chk("t6 rearmed", rd_valid, 0);
        next_slot();
        chk("t6 captured", rd_valid, 1);
        drain("t6", 0, 200);

        // Restart on the very edge that would capture.
        pulse_line(23'h001000, 4);
        next_slot();
        while (!slot_start) step();
        pulse_line(23'h002000, 2);
        chk("t7 capture dropped", rd_valid, 0);
        chk("t7 new addr", vram_addr, 23'h002000);
        drain("t7", 0, 200);

        // Underflow is sticky and cleared by a new line.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("t8 underflow set", underflow, 1);
        chk("t8 still empty", rd_valid, 0);
        repeat (3) step();
        chk("t8 underflow held", underflow, 1);
        pulse_line(23'h001000, 2);
        chk("t8 underflow cleared", underflow, 0);

        // Reset in the middle of a line.
        next_slot();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("t9 underflow pre", underflow, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("t9 vram_addr", vram_addr, 0);
        chk("t9 busy", busy, 0);
        chk("t9 rd_valid", rd_valid, 0);
        chk("t9 underflow", underflow, 0);
        repeat (4) next_slot();
        chk("t9 ignored dout", rd_valid, 0);
        chk("t9 idle", busy, 0);

        // Randomised lines with random CPU slots and consumer pacing.
        for (int k = 0; k < 8; k++) begin
            pulse_line(23'($urandom), $urandom_range(1, 10));
            drain($sformatf("rnd%0d", k), 1, 3000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
